// File: rtl/data_mem_access_unit.sv
// rtl/data_mem_access_unit.sv - load/store bus engine for the MEM stage with stall, error and timeout
module data_mem_access_unit #(
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid_m,
   input  logic        i_mem_write_m,
   input  logic [2:0]  i_funct3_m,
   input  logic [31:0] i_alu_result_m,
   input  logic [31:0] i_write_data_m,
   output logic [31:0] o_read_data_m,
   output logic        o_stall_mem,
   output logic        o_err_m,
   output logic        o_mem_req,
   output logic        o_mem_we,
   output logic [31:0] o_mem_addr,
   output logic [31:0] o_mem_wdata,
   output logic [3:0]  o_mem_be,
   input  logic        i_mem_gnt,
   input  logic        i_mem_rvalid,
   input  logic [31:0] i_mem_rdata
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [CW-1:0] r_cnt;
   logic [31:0]   r_mem_addr;
   logic [31:0]   r_mem_wdata;
   logic [31:0]   r_read_data;
   logic [3:0]    r_mem_be;
   logic          r_mem_we;
   logic [2:0]    r_funct3;
   logic [1:0]    r_off;

   logic          w_illegal;
   logic          w_misalign;
   logic          w_idle_err;
   logic          w_accept;
   logic          w_timeout;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic [31:0]   w_shifted;
   logic [31:0]   w_load_ext;

   // classify the incoming access: illegal funct3 or misaligned address is rejected in IDLE
   always_comb begin
      w_illegal  = 1'b0;
      w_misalign = 1'b0;
      if (i_mem_write_m) begin
         w_illegal = (i_funct3_m > 3'b010);
      end else begin
         w_illegal = (i_funct3_m == 3'b011) || (i_funct3_m == 3'b110) || (i_funct3_m == 3'b111);
      end
      w_misalign = ((i_funct3_m[1:0] == 2'b01) && i_alu_result_m[0]) ||
                   ((i_funct3_m[1:0] == 2'b10) && (i_alu_result_m[1:0] != 2'b00));
      w_idle_err = (r_state == S_IDLE) && i_req_valid_m && (w_illegal || w_misalign);
      w_accept   = (r_state == S_IDLE) && i_req_valid_m && !(w_illegal || w_misalign);
   end

   // place store data on its byte lanes and derive the matching byte enables
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_write_data_m;
      case (i_funct3_m[1:0])
         2'b00: begin
            w_be    = 4'b0001 << i_alu_result_m[1:0];
            w_wdata = {4{i_write_data_m[7:0]}};
         end
         2'b01: begin
            w_be    = i_alu_result_m[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{i_write_data_m[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_write_data_m;
         end
      endcase
   end

   // pick the addressed byte/half of the returned word and extend it
   always_comb begin
      w_shifted = i_mem_rdata >> {r_off, 3'b000};
      case (r_funct3)
         3'b000:  w_load_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
         3'b001:  w_load_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
         3'b100:  w_load_ext = {24'd0, w_shifted[7:0]};
         3'b101:  w_load_ext = {16'd0, w_shifted[15:0]};
         default: w_load_ext = i_mem_rdata;
      endcase
   end

   // next-state logic; a grant or rvalid in the last allowed cycle still wins over the timeout
   always_comb begin
      w_next    = r_state;
      w_timeout = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_REQ;
         end
         S_REQ: begin
            if (i_mem_gnt) begin
               w_next = r_mem_we ? S_DONE : S_WAIT;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_timeout = 1'b1;
               w_next    = S_DONE;
            end
         end
         S_WAIT: begin
            if (i_mem_rvalid) begin
               w_next = S_DONE;
            end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
               w_timeout = 1'b1;
               w_next    = S_DONE;
            end
         end
         S_DONE: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // state, timeout counter, latched bus fields and load result
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_mem_be    <= '0;
         r_mem_we    <= 1'b0;
         r_funct3    <= '0;
         r_off       <= '0;
         r_read_data <= '0;
      end else begin
         r_state <= w_next;
         if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
            r_cnt <= r_cnt + CW'(1);
         end else begin
            r_cnt <= '0;
         end
         if (w_accept) begin
            r_mem_addr  <= {i_alu_result_m[31:2], 2'b00};
            r_mem_wdata <= w_wdata;
            r_mem_be    <= w_be;
            r_mem_we    <= i_mem_write_m;
            r_funct3    <= i_funct3_m;
            r_off       <= i_alu_result_m[1:0];
         end
         if (w_idle_err || w_timeout) begin
            r_read_data <= '0;
         end else if ((r_state == S_WAIT) && i_mem_rvalid) begin
            r_read_data <= w_load_ext;
         end
      end
   end

   assign o_mem_req     = (r_state == S_REQ);
   assign o_mem_we      = r_mem_we;
   assign o_mem_addr    = r_mem_addr;
   assign o_mem_wdata   = r_mem_wdata;
   assign o_mem_be      = r_mem_be;
   assign o_err_m       = w_idle_err || w_timeout;
   assign o_read_data_m = o_err_m ? 32'd0 : r_read_data;
   assign o_stall_mem   = i_req_valid_m && (r_state != S_DONE) && !w_idle_err;

endmodule
